pixel_dirty_tracker: RTL and testbench
======================================

// Module: pixel_dirty_tracker
// PURPOSE
//  Per-pixel "updated" flag store for the GPU line buffer. It tracks which line-buffer entries are
//  fresh, so stale entries are never shown. Three flag banks rotate through three roles:
//  update (written by the current scanline), scan (read by display output) and clear (swept to zero).
//  Parametrised in line width and pixels per word. Adds a power-on init sweep, clear-done status and
//  a sticky overrun flag. Sits between the scanline renderer and the VGA output stage.
// PARAMETERS
//  LINE_PIXELS   640  visible pixels per line
//  PIX_PER_WORD  4    flags per RAM word; power of two, >=1
//  WORDS         LINE_PIXELS/PIX_PER_WORD (derived localparam); ADDR_W=clog2(WORDS), X_W=clog2(LINE_PIXELS)
// PORTS
//  clk           in   1             system clock, rising edge
//  reset_n       in   1             asynchronous, active-low reset
//  line_advance  in   1             1-cycle pulse at line boundary; rotates bank roles
//  wr_en         in   1             OR wr_mask into update bank at wr_addr
//  wr_addr       in   ADDR_W        update-bank word address
//  wr_mask       in   PIX_PER_WORD  flags to set (bit i = pixel wr_addr*PPW+i)
//  rd_flags      out  PIX_PER_WORD  combinational: update-bank word at wr_addr
//  scan_x        in   X_W           display pixel column
//  scan_enable   out  1             registered flag of pixel scan_x in scan bank
//  phase         out  2             current rotation phase 0..2
//  clear_busy    out  1             clear sweep (or init sweep) in progress
//  overrun       out  1             sticky: line_advance arrived while clear_busy
//  overrun_clr   in   1             clears overrun (set wins if same cycle)
// BEHAVIOUR
//  - Banks B0..B2. Roles: phase0 upd=B0 scan=B1 clr=B2; phase1 upd=B2 scan=B0 clr=B1;
//    phase2 upd=B1 scan=B2 clr=B0.
//  - Rotation: cleared bank -> update, updated bank -> scan, scanned bank -> clear.
//  - Reset values: phase=0, scan_enable=0, overrun=0, clear_busy=1, clear counter=0, state=INIT.
//  - FSM INIT: writes 0 to word cnt of ALL three banks, cnt++ per cycle. After cnt=WORDS-1 -> IDLE,
//    clear_busy=0. In INIT: wr_en and line_advance ignored; scan_enable forced 0.
//  - FSM IDLE: on line_advance, phase <= (phase==2)?0:phase+1, cnt<=0, -> CLEAR, clear_busy=1.
//  - FSM CLEAR: writes 0 to clr-bank word cnt, cnt++ per cycle. After cnt=WORDS-1 -> IDLE, clear_busy=0.
//    A full sweep takes exactly WORDS cycles.
//  - line_advance in CLEAR: rotate as in IDLE, set overrun, restart cnt=0 on the new clr bank.
//    Unswept words of the old clr bank (now update) keep stale flags; no other recovery.
//  - Write: update[wr_addr] <= update[wr_addr] | wr_mask, one cycle (async-read RAM, read-modify-write).
//    wr_addr>=WORDS: write dropped.
//    wr_en in the same cycle as line_advance: write goes to the pre-rotation update bank.
//  - rd_flags: combinational, uses current phase, reflects writes from previous cycles.
//  - scan_enable: 1-cycle latency. scan_enable <= scan[scan_x/PPW][scan_x%PPW].
//    scan_x>=LINE_PIXELS gives 0. The phase sampled is the pre-edge phase.
//  - Scan and clear banks are never written by the update port, so no address conflicts exist.
//  - reset_n low mid-operation: all registers return to reset values immediately; INIT restarts.
// TESTING
//  1. Reset release (640/4): clear_busy=1 for exactly 160 cycles, then 0. All rd_flags=0,
//     and scan_enable=0 for every x.
//  2. phase0: wr 5 mask 4'b0010, then wr 5 mask 4'b1000 -> rd_flags=4'b1010.
//     After line_advance: phase=1, scan_x=21 -> scan_enable=1; x=20,22 -> 0.
//  3. Two more line_advance (each after clear done) -> phase 2 then 0.
//     Flags written in phase0 are cleared when that bank rotates into clear; rewritten bank reads 0.
//  4. line_advance 50 cycles into CLEAR -> overrun=1, phase advances, clear_busy stays 1
//     for 160 more cycles. overrun_clr -> 0.
//  5. wr_en + line_advance same cycle -> flag appears in new scan bank next line, not in new update bank.
//  6. wr_addr=200 -> no bank changes. scan_x=700 -> scan_enable=0.
//     reset_n pulsed low mid-CLEAR -> phase=0, INIT re-runs 160 cycles.

Source files
------------

// File: rtl/pixel_dirty_tracker_if.sv
// Bus bundle for pixel_dirty_tracker.
//   master: renderer/display side (drives line_advance, writes, scan_x, overrun_clr)
//   slave : the tracker itself (drives rd_flags, scan_enable, phase, clear_busy, overrun)
interface pixel_dirty_tracker_if #(
  parameter int unsigned LINE_PIXELS  = 640,
  parameter int unsigned PIX_PER_WORD = 4
);
  localparam int unsigned WORDS  = LINE_PIXELS / PIX_PER_WORD;
  localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned X_W    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

  logic                    line_advance;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [PIX_PER_WORD-1:0] wr_mask;
  logic [PIX_PER_WORD-1:0] rd_flags;
  logic [X_W-1:0]          scan_x;
  logic                    scan_enable;
  logic [1:0]              phase;
  logic                    clear_busy;
  logic                    overrun;
  logic                    overrun_clr;

  modport master (
    output line_advance, wr_en, wr_addr, wr_mask, scan_x, overrun_clr,
    input  rd_flags, scan_enable, phase, clear_busy, overrun
  );

  modport slave (
    input  line_advance, wr_en, wr_addr, wr_mask, scan_x, overrun_clr,
    output rd_flags, scan_enable, phase, clear_busy, overrun
  );
endinterface

// File: rtl/pixel_dirty_tracker.sv
// Per-pixel "updated" flag store for the line buffer. Three flag banks rotate through the
// update / scan / clear roles on every line_advance.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : line_advance, wr_en/wr_addr/wr_mask, rd_flags (comb), scan_x,
//                  scan_enable (registered), phase, clear_busy, overrun (sticky), overrun_clr
module pixel_dirty_tracker #(
  parameter int unsigned LINE_PIXELS  = 640,
  parameter int unsigned PIX_PER_WORD = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  pixel_dirty_tracker_if.slave bus
);
  localparam int unsigned WORDS  = LINE_PIXELS / PIX_PER_WORD;
  localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned X_W    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned BIT_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  // One extra bit so the bounds compare works when WORDS / LINE_PIXELS are powers of two.
  localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W + 1)'(WORDS);
  localparam logic [X_W:0]      PIX_EXT   = (X_W + 1)'(LINE_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [1:0]              phase_q, phase_d;
  logic                    overrun_q, overrun_d;
  logic                    scan_enable_q, scan_enable_d;

  logic [PIX_PER_WORD-1:0] bank_q [3][WORDS];

  logic [1:0]              upd_sel, scan_sel, clr_sel;
  logic [1:0]              phase_next;
  logic                    addr_ok, wr_ok, x_ok;
  logic [PIX_PER_WORD-1:0] upd_word, scan_word_data;
  logic [ADDR_W-1:0]       scan_word;
  logic [BIT_W-1:0]        scan_bit;

  // Bank roles per phase: cleared bank becomes update, updated becomes scan, scanned becomes clear.
  always_comb begin
    upd_sel  = 2'd0;
    scan_sel = 2'd1;
    clr_sel  = 2'd2;
    case (phase_q)
      2'd1: begin
        upd_sel  = 2'd2;
        scan_sel = 2'd0;
        clr_sel  = 2'd1;
      end
      2'd2: begin
        upd_sel  = 2'd1;
        scan_sel = 2'd2;
        clr_sel  = 2'd0;
      end
      default: ;
    endcase
  end

  assign phase_next = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;

  assign addr_ok  = {1'b0, bus.wr_addr} < WORDS_EXT;
  assign upd_word = addr_ok ? bank_q[upd_sel][bus.wr_addr] : '0;
  assign wr_ok    = bus.wr_en && (state_q != StInit) && addr_ok;

  assign x_ok           = {1'b0, bus.scan_x} < PIX_EXT;
  assign scan_word      = ADDR_W'(bus.scan_x / X_W'(PIX_PER_WORD));
  assign scan_bit       = BIT_W'(bus.scan_x % X_W'(PIX_PER_WORD));
  assign scan_word_data = x_ok ? bank_q[scan_sel][scan_word] : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    overrun_d     = overrun_q;
    scan_enable_d = (state_q != StInit) && x_ok && scan_word_data[scan_bit];

    if (bus.overrun_clr) overrun_d = 1'b0;

    case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.line_advance) begin
          phase_d = phase_next;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (bus.line_advance) begin
          // Sweep restarts on the new clear bank; the abandoned words stay stale.
          phase_d   = phase_next;
          cnt_d     = '0;
          overrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StInit;
      cnt_q         <= '0;
      phase_q       <= 2'd0;
      overrun_q     <= 1'b0;
      scan_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      overrun_q     <= overrun_d;
      scan_enable_q <= scan_enable_d;
    end
  end

  // Flag RAM: no reset, contents are established by the INIT sweep.
  // Update and clear banks always differ, so the two writes never collide.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      for (int b = 0; b < 3; b++) bank_q[b][cnt_q] <= '0;
    end else begin
      if (state_q == StClear) bank_q[clr_sel][cnt_q] <= '0;
      if (wr_ok) bank_q[upd_sel][bus.wr_addr] <= upd_word | bus.wr_mask;
    end
  end

  assign bus.rd_flags    = upd_word;
  assign bus.scan_enable = scan_enable_q;
  assign bus.phase       = phase_q;
  assign bus.clear_busy  = (state_q != StIdle);
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pixel_dirty_tracker.sv
// Directed bench for pixel_dirty_tracker (640 pixels, 4 flags per word).
module tb_pixel_dirty_tracker;
  logic clk;
  logic reset_n;
  int   tests_run;
  int   failures;

  pixel_dirty_tracker_if #(.LINE_PIXELS(640), .PIX_PER_WORD(4)) bus ();

  pixel_dirty_tracker #(.LINE_PIXELS(640), .PIX_PER_WORD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.clear_busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic advance();
    bus.line_advance = 1'b1;
    tick();
    bus.line_advance = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    bus.line_advance = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_mask      = '0;
    bus.scan_x       = '0;
    bus.overrun_clr  = 1'b0;
    reset_n          = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (bus.phase !== 2'd0 || bus.clear_busy !== 1'b1 || bus.overrun !== 1'b0
        || bus.scan_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got phase=%0d busy=%0b ovr=%0b se=%0b, expected 0 1 0 0",
               bus.phase, bus.clear_busy, bus.overrun, bus.scan_enable);
    end
    reset_n = 1'b1;
    wait_idle(n);
    tests_run++;
    if (n != 160) begin
      failures++;
      $display("FAIL init_length: got %0d cycles busy, expected 160", n);
    end
    bad = 0;
    for (int a = 0; a < 160; a++) begin
      bus.wr_addr = 8'(a);
      #1;
      if (bus.rd_flags !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_rd_flags: got %0d nonzero words, expected 0", bad);
    end
    bad = 0;
    for (int x = 0; x < 640; x++) begin
      bus.scan_x = 10'(x);
      tick();
      if (bus.scan_enable !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_scan: got %0d set pixels, expected 0", bad);
    end
  endtask

  task automatic test_write_scan();
    logic [9:0] xs [4] = '{10'd20, 10'd21, 10'd22, 10'd23};
    logic       es [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd5;
    bus.wr_mask = 4'b0010;
    tick();
    bus.wr_mask = 4'b1000;
    tick();
    bus.wr_en = 1'b0;
    #1;
    tests_run++;
    if (bus.rd_flags !== 4'b1010) begin
      failures++;
      $display("FAIL rmw_or: got %b, expected 1010", bus.rd_flags);
    end
    advance();
    tests_run++;
    if (bus.phase !== 2'd1 || bus.clear_busy !== 1'b1) begin
      failures++;
      $display("FAIL advance_phase1: got phase=%0d busy=%0b, expected 1 1",
               bus.phase, bus.clear_busy);
    end
    tests_run++;
    if (bus.rd_flags !== 4'b0000) begin
      failures++;
      $display("FAIL new_update_bank_clean: got %b, expected 0000", bus.rd_flags);
    end
    for (int i = 0; i < 4; i++) begin
      bus.scan_x = xs[i];
      tick();
      tests_run++;
      if (bus.scan_enable !== es[i]) begin
        failures++;
        $display("FAIL scan_x%0d: got %0b, expected %0b", xs[i], bus.scan_enable, es[i]);
      end
    end
    wait_idle(n);
    tests_run++;
    if (n >= 400) begin
      failures++;
      $display("FAIL clear_timeout1: got %0d cycles, expected < 400", n);
    end
  endtask

  task automatic test_rotation();
    int n;
    advance();
    tests_run++;
    if (bus.phase !== 2'd2) begin
      failures++;
      $display("FAIL phase2: got %0d, expected 2", bus.phase);
    end
    wait_idle(n);
    bus.scan_x = 10'd21;
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b0) begin
      failures++;
      $display("FAIL phase2_scan21: got %0b, expected 0", bus.scan_enable);
    end
    advance();
    bus.wr_addr = 8'd5;
    #1;
    tests_run++;
    if (bus.phase !== 2'd0 || bus.rd_flags !== 4'b0000) begin
      failures++;
      $display("FAIL phase0_cleared: got phase=%0d flags=%b, expected 0 0000",
               bus.phase, bus.rd_flags);
    end
    wait_idle(n);
    tests_run++;
    if (n >= 400) begin
      failures++;
      $display("FAIL clear_timeout2: got %0d cycles, expected < 400", n);
    end
  endtask

  task automatic test_overrun();
    int n;
    advance();
    repeat (50) tick();
    advance();
    tests_run++;
    if (bus.overrun !== 1'b1 || bus.phase !== 2'd2 || bus.clear_busy !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got ovr=%0b phase=%0d busy=%0b, expected 1 2 1",
               bus.overrun, bus.phase, bus.clear_busy);
    end
    wait_idle(n);
    tests_run++;
    if (n != 160) begin
      failures++;
      $display("FAIL overrun_sweep_len: got %0d cycles, expected 160", n);
    end
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: got %0b, expected 1", bus.overrun);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    tests_run++;
    if (bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: got %0b, expected 0", bus.overrun);
    end
    // Set and clear in the same cycle: set wins.
    advance();
    repeat (3) tick();
    bus.overrun_clr  = 1'b1;
    bus.line_advance = 1'b1;
    tick();
    bus.overrun_clr  = 1'b0;
    bus.line_advance = 1'b0;
    tests_run++;
    if (bus.overrun !== 1'b1 || bus.phase !== 2'd1) begin
      failures++;
      $display("FAIL overrun_set_wins: got ovr=%0b phase=%0d, expected 1 1",
               bus.overrun, bus.phase);
    end
    wait_idle(n);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    bus.wr_en        = 1'b1;
    bus.wr_addr      = 8'd10;
    bus.wr_mask      = 4'b0001;
    bus.line_advance = 1'b1;
    tick();
    bus.wr_en        = 1'b0;
    bus.line_advance = 1'b0;
    #1;
    tests_run++;
    if (bus.phase !== 2'd2 || bus.rd_flags !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_update_bank: got phase=%0d flags=%b, expected 2 0000",
               bus.phase, bus.rd_flags);
    end
    bus.scan_x = 10'd40;
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b1) begin
      failures++;
      $display("FAIL b2b_scan40: got %0b, expected 1", bus.scan_enable);
    end
    bus.scan_x = 10'd41;
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b0) begin
      failures++;
      $display("FAIL b2b_scan41: got %0b, expected 0", bus.scan_enable);
    end
    wait_idle(n);
  endtask

  task automatic test_bounds();
    int n;
    int bad;
    int seen;
    // phase 2: update bank has been fully swept
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd200;
    bus.wr_mask = 4'b1111;
    tick();
    bus.wr_addr = 8'd159;
    bus.wr_mask = 4'b1000;
    tick();
    bus.wr_en = 1'b0;
    #1;
    tests_run++;
    if (bus.rd_flags !== 4'b1000) begin
      failures++;
      $display("FAIL last_word_write: got %b, expected 1000", bus.rd_flags);
    end
    bad = 0;
    for (int a = 0; a < 159; a++) begin
      bus.wr_addr = 8'(a);
      #1;
      if (bus.rd_flags !== 4'b0000) bad++;
    end
    bus.wr_addr = 8'd200;
    #1;
    if (bus.rd_flags !== 4'b0000) bad++;
    tests_run++;
    if (bad != 0) begin
      failures++;
      $display("FAIL oob_write_dropped: got %0d nonzero words, expected 0", bad);
    end
    advance();
    bus.scan_x = 10'd639;
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b1) begin
      failures++;
      $display("FAIL scan_x639: got %0b, expected 1", bus.scan_enable);
    end
    bus.scan_x = 10'd700;
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b0) begin
      failures++;
      $display("FAIL scan_x700: got %0b, expected 0", bus.scan_enable);
    end
    // Mid-clear reset: async return to reset values, INIT reruns and forces scan_enable low.
    bus.scan_x = 10'd639;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.phase !== 2'd0 || bus.clear_busy !== 1'b1 || bus.scan_enable !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got phase=%0d busy=%0b se=%0b, expected 0 1 0",
               bus.phase, bus.clear_busy, bus.scan_enable);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    n    = 0;
    seen = 0;
    while (bus.clear_busy && n < 400) begin
      tick();
      n++;
      if (bus.scan_enable !== 1'b0) seen++;
    end
    tests_run++;
    if (n != 160) begin
      failures++;
      $display("FAIL reinit_length: got %0d cycles, expected 160", n);
    end
    tests_run++;
    if (seen != 0) begin
      failures++;
      $display("FAIL init_scan_forced: got %0d high cycles, expected 0", seen);
    end
    tick();
    tests_run++;
    if (bus.scan_enable !== 1'b0 || bus.phase !== 2'd0) begin
      failures++;
      $display("FAIL reinit_cleared: got se=%0b phase=%0d, expected 0 0",
               bus.scan_enable, bus.phase);
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    reset_n   = 1'b0;
    test_reset();
    test_write_scan();
    test_rotation();
    test_overrun();
    test_back_to_back();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
